// File: rtl/regfile_wb_scheduler_pkg.sv
// regfile_wb_scheduler_pkg: shared register-file geometry and index types
package regfile_wb_scheduler_pkg;
  localparam int RF_NREQ = 2;
  localparam int RF_DATA_W = 16;
  localparam int RF_REG_AW = 3;
  localparam int RF_NREGS = 2 ** RF_REG_AW;
  typedef logic [RF_REG_AW-1:0] rf_idx_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: writeback requester bundle, one lane per requester
interface regfile_wb_scheduler_if
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DATA_W = RF_DATA_W,
  parameter int REG_AW = RF_REG_AW
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*REG_AW-1:0] req_reg;
  logic [NREQ*DATA_W-1:0] req_data;
  modport master (output req_valid, req_reg, req_data, input req_ready);
  modport slave (input req_valid, req_reg, req_data, output req_ready);
endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant, search starts at rr_ptr and wraps
module rr_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int N = RF_NREQ,
  localparam int PW = ptr_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] valid,
  output logic [N-1:0] grant
);
  logic [PW-1:0] rr_ptr, gidx, j;
  logic hit;
  always_comb begin
    grant = '0;
    gidx = rr_ptr;
    hit = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(rr_ptr) + i) % N);
      if (!hit && valid[j]) begin
        hit = 1'b1;
        grant[j] = 1'b1;
        gidx = j;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (hit) rr_ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: round-robin writeback onto one register-file write port
// plus a busy-bit scoreboard for RAW/WAW stalls
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int NREQ = RF_NREQ,
  parameter int DATA_W = RF_DATA_W,
  parameter int REG_AW = RF_REG_AW,
  localparam int NREGS = 2 ** REG_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_scheduler_if.slave wb,
  input  logic                 rsv_valid,
  input  logic [REG_AW-1:0]    rsv_reg,
  output logic                 rsv_ready,
  input  logic [REG_AW-1:0]    chk_reg1,
  input  logic [REG_AW-1:0]    chk_reg2,
  output logic                 chk_busy1,
  output logic                 chk_busy2,
  output logic [NREGS-1:0]     busy,
  output logic                 rf_write,
  output logic [REG_AW-1:0]    rf_wreg,
  output logic [DATA_W-1:0]    rf_wd,
  output logic                 err_unrsv
);
  logic [NREQ-1:0] grant;
  logic [REG_AW-1:0] g_reg;
  logic [DATA_W-1:0] g_data;
  logic [NREGS-1:0] set, clr;
  rr_arbiter #(.N(NREQ)) u_arb (.clk, .rst_n, .valid(wb.req_valid), .grant);
  assign wb.req_ready = grant;
  always_comb begin
    g_reg = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant[i]) begin
        g_reg = wb.req_reg[i*REG_AW +: REG_AW];
        g_data = wb.req_data[i*DATA_W +: DATA_W];
      end
  end
  assign rsv_ready = ~busy[rsv_reg];
  assign chk_busy1 = busy[chk_reg1];
  assign chk_busy2 = busy[chk_reg2];
  // set is OR-ed after the clear so a same-index reservation wins
  assign set = (rsv_valid && rsv_ready) ? NREGS'(1) << rsv_reg : '0;
  assign clr = rf_write ? NREGS'(1) << rf_wreg : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= '0;
      rf_write <= 1'b0;
      rf_wreg <= '0;
      rf_wd <= '0;
      err_unrsv <= 1'b0;
    end else begin
      busy <= (busy & ~clr) | set;
      rf_write <= |grant;
      if (|grant) begin
        rf_wreg <= g_reg;
        rf_wd <= g_data;
      end
      err_unrsv <= rf_write & ~busy[rf_wreg];
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed vectors with hand-computed expectations
module tb_regfile_wb_scheduler;
  import regfile_wb_scheduler_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rsv_valid, rsv_ready, chk_busy1, chk_busy2, rf_write, err_unrsv;
  rf_idx_t rsv_reg, chk_reg1, chk_reg2, rf_wreg;
  logic [7:0] busy;
  logic [15:0] rf_wd;
  int tests = 0;
  int fails = 0;
  regfile_wb_scheduler_if #(.NREQ(2), .DATA_W(16), .REG_AW(3)) wb ();
  regfile_wb_scheduler #(.NREQ(2), .DATA_W(16), .REG_AW(3)) dut (
    .clk, .rst_n, .wb, .rsv_valid, .rsv_reg, .rsv_ready, .chk_reg1, .chk_reg2,
    .chk_busy1, .chk_busy2, .busy, .rf_write, .rf_wreg, .rf_wd, .err_unrsv
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [1:0] v, input rf_idx_t r0, input logic [15:0] d0,
                     input rf_idx_t r1, input logic [15:0] d1);
    wb.req_valid = v;
    wb.req_reg = {r1, r0};
    wb.req_data = {d1, d0};
  endtask
  initial begin
    req(2'b00, 0, 0, 0, 0);
    rsv_valid = 0; rsv_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
    repeat (2) tick;
    check("rst_busy", busy, 8'h00);
    check("rst_wr", rf_write, 0);
    check("rst_wreg", rf_wreg, 0);
    check("rst_wd", rf_wd, 0);
    check("rst_err", err_unrsv, 0);
    rst_n = 1;
    tick;
    // single reserved write
    rsv_valid = 1; rsv_reg = 3;
    #1 check("rsv3_rdy", rsv_ready, 1);
    tick;
    rsv_valid = 0;
    check("rsv3_busy", busy, 8'h08);
    chk_reg1 = 3; chk_reg2 = 2;
    #1 check("chk1", chk_busy1, 1);
    check("chk2", chk_busy2, 0);
    req(2'b01, 3, 16'hBEEF, 0, 0);
    #1 check("w3_ready", wb.req_ready, 2'b01);
    tick;
    wb.req_valid = 0;
    check("w3_wr", rf_write, 1);
    check("w3_wreg", rf_wreg, 3);
    check("w3_wd", rf_wd, 16'hBEEF);
    check("w3_busy_during", busy, 8'h08);
    check("w3_chk_during", chk_busy1, 1);
    tick;
    check("w3_wr_off", rf_write, 0);
    check("w3_busy_after", busy, 8'h00);
    check("w3_wd_hold", rf_wd, 16'hBEEF);
    check("w3_wreg_hold", rf_wreg, 3);
    check("w3_err", err_unrsv, 0);
    check("w3_chk_after", chk_busy1, 0);
    // unreserved write by requester 1 (rr_ptr is 1 here)
    req(2'b10, 0, 0, 6, 16'h1234);
    #1 check("w6_ready", wb.req_ready, 2'b10);
    tick;
    wb.req_valid = 0;
    check("w6_wr", rf_write, 1);
    check("w6_wreg", rf_wreg, 6);
    check("w6_wd", rf_wd, 16'h1234);
    check("w6_err_pre", err_unrsv, 0);
    tick;
    check("w6_err", err_unrsv, 1);
    check("w6_wr_off", rf_write, 0);
    check("w6_busy", busy, 8'h00);
    tick;
    check("w6_err_off", err_unrsv, 0);
    // contention: rr_ptr back at 0
    req(2'b11, 1, 16'hA001, 2, 16'hB002);
    for (int k = 0; k < 4; k++) begin
      #1 check("rr_grant", wb.req_ready, (k % 2) ? 2'b10 : 2'b01);
      if (k > 0) check("rr_wreg", rf_wreg, (k % 2) ? 1 : 2);
      tick;
    end
    wb.req_valid = 0;
    check("rr_last_wr", rf_write, 1);
    check("rr_last_wreg", rf_wreg, 2);
    check("rr_last_wd", rf_wd, 16'hB002);
    tick;
    check("rr_drain", rf_write, 0);
    // WAW stall on r5
    rsv_valid = 1; rsv_reg = 5;
    #1 check("r5_rdy", rsv_ready, 1);
    tick;
    check("r5_busy", busy, 8'h20);
    #1 check("waw_rdy", rsv_ready, 0);
    tick;
    check("waw_busy", busy, 8'h20);
    rsv_valid = 0;
    req(2'b01, 5, 16'h5555, 0, 0);
    #1 check("w5_ready", wb.req_ready, 2'b01);
    tick;
    wb.req_valid = 0;
    check("w5_wreg", rf_wreg, 5);
    // clear r5 and set r4 at the same edge
    rsv_valid = 1; rsv_reg = 4;
    #1 check("r4_rdy", rsv_ready, 1);
    tick;
    rsv_valid = 0;
    check("diff_idx_busy", busy, 8'h10);
    check("w5_err", err_unrsv, 0);
    rsv_valid = 1; rsv_reg = 5;
    #1 check("r5_again_rdy", rsv_ready, 1);
    tick;
    rsv_valid = 0;
    check("r5_again_busy", busy, 8'h30);
    // same-index set and clear: r7 unreserved at commit, reserved at that edge
    req(2'b01, 7, 16'h7777, 0, 0);
    #1 check("w7_ready", wb.req_ready, 2'b01);
    tick;
    wb.req_valid = 0;
    check("w7_wr", rf_write, 1);
    check("w7_wreg", rf_wreg, 7);
    rsv_valid = 1; rsv_reg = 7;
    #1 check("r7_rdy", rsv_ready, 1);
    tick;
    rsv_valid = 0;
    check("same_idx_busy", busy, 8'hB0);
    check("same_idx_err", err_unrsv, 1);
    // async reset during live traffic with a write in flight
    req(2'b01, 2, 16'h2222, 0, 0);
    rsv_valid = 1; rsv_reg = 2;
    tick;
    check("pre_rst_wr", rf_write, 1);
    check("pre_rst_busy", busy, 8'hB4);
    #4 rst_n = 0;
    #1 check("arst_busy", busy, 8'h00);
    check("arst_wr", rf_write, 0);
    check("arst_err", err_unrsv, 0);
    check("arst_wd", rf_wd, 0);
    check("arst_wreg", rf_wreg, 0);
    rsv_valid = 0;
    tick;
    check("hold_rst_wr", rf_write, 0);
    wb.req_valid = 0;
    rst_n = 1;
    tick;
    check("post_rst_wr", rf_write, 0);
    check("post_rst_busy", busy, 8'h00);
    req(2'b11, 1, 16'h0001, 2, 16'h0002);
    #1 check("post_rst_ptr", wb.req_ready, 2'b01);
    tick;
    wb.req_valid = 0;
    check("post_rst_wreg", rf_wreg, 1);
    tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
